// File: rtl/baccarat_datapath.sv
// Baccarat card-holding and scoring datapath: six card registers, combinational
// hand scores, and saturating win/loss/tie/round tallies driven by the result lights.
module baccarat_datapath #(
    parameter int TALLY_W = 8
) (
    input  logic               slow_clock,
    input  logic               reset,
    input  logic [3:0]         new_card,
    input  logic               load_pcard1,
    input  logic               load_pcard2,
    input  logic               load_pcard3,
    input  logic               load_dcard1,
    input  logic               load_dcard2,
    input  logic               load_dcard3,
    input  logic               player_win_light,
    input  logic               dealer_win_light,
    output logic [3:0]         pcard1_out,
    output logic [3:0]         pcard2_out,
    output logic [3:0]         pcard3_out,
    output logic [3:0]         dcard1_out,
    output logic [3:0]         dcard2_out,
    output logic [3:0]         dcard3_out,
    output logic [3:0]         pcard3,
    output logic [3:0]         pscore,
    output logic [3:0]         dscore,
    output logic [TALLY_W-1:0] player_wins,
    output logic [TALLY_W-1:0] dealer_wins,
    output logic [TALLY_W-1:0] ties,
    output logic [TALLY_W-1:0] rounds
);

    localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};
    localparam logic [TALLY_W-1:0] TALLY_ONE = {{(TALLY_W-1){1'b0}}, 1'b1};

    logic [3:0]         pcard1_r, pcard2_r, pcard3_r;
    logic [3:0]         dcard1_r, dcard2_r, dcard3_r;
    logic               result_seen_r;
    logic [TALLY_W-1:0] player_wins_r, dealer_wins_r, ties_r, rounds_r;
    logic [3:0]         card_s;
    logic               new_round_s, bump_p_s, bump_d_s, bump_t_s;

    function automatic logic [3:0] sanitize(input logic [3:0] c);
        case (c)
            4'd0, 4'd14, 4'd15: sanitize = 4'd0;
            default:            sanitize = c;
        endcase
    endfunction

    function automatic logic [3:0] card_value(input logic [3:0] c);
        if (c >= 4'd1 && c <= 4'd9) card_value = c;
        else                        card_value = 4'd0;
    endfunction

    // Raw sum never exceeds 27, so mod 10 needs at most two subtractions.
    function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] sum;
        sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
        if (sum >= 5'd20)      sum = sum - 5'd20;
        else if (sum >= 5'd10) sum = sum - 5'd10;
        else                   sum = sum;
        hand_score = sum[3:0];
    endfunction

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] x,
                                                   input logic en);
        if (en && x != TALLY_MAX) sat_inc = x + TALLY_ONE;
        else                      sat_inc = x;
    endfunction

    // Decode incoming card and classify the rising edge of the result lights.
    always_comb begin
        card_s      = sanitize(new_card);
        new_round_s = (player_win_light | dealer_win_light) & ~result_seen_r;
        bump_t_s    = new_round_s & player_win_light & dealer_win_light;
        bump_p_s    = new_round_s & player_win_light & ~dealer_win_light;
        bump_d_s    = new_round_s & dealer_win_light & ~player_win_light;
    end

    // Card registers; loading the first player card starts a fresh round.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            pcard1_r <= 4'd0; pcard2_r <= 4'd0; pcard3_r <= 4'd0;
            dcard1_r <= 4'd0; dcard2_r <= 4'd0; dcard3_r <= 4'd0;
        end else begin
            if (load_pcard1) pcard1_r <= card_s;
            if (load_pcard2)      pcard2_r <= card_s;
            else if (load_pcard1) pcard2_r <= 4'd0;
            if (load_pcard3)      pcard3_r <= card_s;
            else if (load_pcard1) pcard3_r <= 4'd0;
            if (load_dcard1)      dcard1_r <= card_s;
            else if (load_pcard1) dcard1_r <= 4'd0;
            if (load_dcard2)      dcard2_r <= card_s;
            else if (load_pcard1) dcard2_r <= 4'd0;
            if (load_dcard3)      dcard3_r <= card_s;
            else if (load_pcard1) dcard3_r <= 4'd0;
        end
    end

    // Round tallies count once per light assertion and saturate independently.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            result_seen_r <= 1'b0;
            player_wins_r <= {TALLY_W{1'b0}};
            dealer_wins_r <= {TALLY_W{1'b0}};
            ties_r        <= {TALLY_W{1'b0}};
            rounds_r      <= {TALLY_W{1'b0}};
        end else begin
            result_seen_r <= player_win_light | dealer_win_light;
            player_wins_r <= sat_inc(player_wins_r, bump_p_s);
            dealer_wins_r <= sat_inc(dealer_wins_r, bump_d_s);
            ties_r        <= sat_inc(ties_r, bump_t_s);
            rounds_r      <= sat_inc(rounds_r, new_round_s);
        end
    end

    assign pcard1_out  = pcard1_r;
    assign pcard2_out  = pcard2_r;
    assign pcard3_out  = pcard3_r;
    assign dcard1_out  = dcard1_r;
    assign dcard2_out  = dcard2_r;
    assign dcard3_out  = dcard3_r;
    assign pcard3      = pcard3_r;
    assign pscore      = hand_score(pcard1_r, pcard2_r, pcard3_r);
    assign dscore      = hand_score(dcard1_r, dcard2_r, dcard3_r);
    assign player_wins = player_wins_r;
    assign dealer_wins = dealer_wins_r;
    assign ties        = ties_r;
    assign rounds      = rounds_r;

endmodule

// File: tb/tb_baccarat_datapath.sv
// Self-checking bench for baccarat_datapath: directed scenarios plus random
// stimulus compared against a behavioural model; a TALLY_W=2 copy checks saturation.
module tb_baccarat_datapath;

    logic       slow_clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] new_card = 4'd0;
    logic [5:0] loads = 6'd0;   // {d3,d2,d1,p3,p2,p1}
    logic       pl = 1'b0, dl = 1'b0;

    logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3, pc3b, ps, ds;
    logic [7:0] pw, dw, tw, rw;
    logic [3:0] pc1_b, pc2_b, pc3_b, dc1_b, dc2_b, dc3_b, pc3b_b, ps_b, ds_b;
    logic [1:0] pw_b, dw_b, tw_b, rw_b;

    int checks = 0;
    int errors = 0;

    // model state
    int pcm [3];
    int dcm [3];
    int cnt_p, cnt_d, cnt_t, cnt_r;
    bit prev_lit;

    baccarat_datapath #(.TALLY_W(8)) dut (
        .slow_clock(slow_clock), .reset(reset), .new_card(new_card),
        .load_pcard1(loads[0]), .load_pcard2(loads[1]), .load_pcard3(loads[2]),
        .load_dcard1(loads[3]), .load_dcard2(loads[4]), .load_dcard3(loads[5]),
        .player_win_light(pl), .dealer_win_light(dl),
        .pcard1_out(pc1), .pcard2_out(pc2), .pcard3_out(pc3),
        .dcard1_out(dc1), .dcard2_out(dc2), .dcard3_out(dc3),
        .pcard3(pc3b), .pscore(ps), .dscore(ds),
        .player_wins(pw), .dealer_wins(dw), .ties(tw), .rounds(rw)
    );

    baccarat_datapath #(.TALLY_W(2)) dut_small (
        .slow_clock(slow_clock), .reset(reset), .new_card(new_card),
        .load_pcard1(loads[0]), .load_pcard2(loads[1]), .load_pcard3(loads[2]),
        .load_dcard1(loads[3]), .load_dcard2(loads[4]), .load_dcard3(loads[5]),
        .player_win_light(pl), .dealer_win_light(dl),
        .pcard1_out(pc1_b), .pcard2_out(pc2_b), .pcard3_out(pc3_b),
        .dcard1_out(dc1_b), .dcard2_out(dc2_b), .dcard3_out(dc3_b),
        .pcard3(pc3b_b), .pscore(ps_b), .dscore(ds_b),
        .player_wins(pw_b), .dealer_wins(dw_b), .ties(tw_b), .rounds(rw_b)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin pcm[i] = 0; dcm[i] = 0; end
        cnt_p = 0; cnt_d = 0; cnt_t = 0; cnt_r = 0; prev_lit = 0;
    endtask

    task automatic model_edge();
        int v;
        bit lit;
        v = (new_card >= 1 && new_card <= 13) ? int'(new_card) : 0;
        if (loads[0]) begin
            pcm[0] = v;
            pcm[1] = 0; pcm[2] = 0; dcm[0] = 0; dcm[1] = 0; dcm[2] = 0;
        end
        if (loads[1]) pcm[1] = v;
        if (loads[2]) pcm[2] = v;
        if (loads[3]) dcm[0] = v;
        if (loads[4]) dcm[1] = v;
        if (loads[5]) dcm[2] = v;
        lit = pl | dl;
        if (lit && !prev_lit) begin
            cnt_r++;
            if (pl && dl) cnt_t++;
            else if (pl)  cnt_p++;
            else          cnt_d++;
        end
        prev_lit = lit;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".pcard1"}, pc1, pcm[0]);
        check_val({tag, ".pcard2"}, pc2, pcm[1]);
        check_val({tag, ".pcard3_out"}, pc3, pcm[2]);
        check_val({tag, ".pcard3"}, pc3b, pcm[2]);
        check_val({tag, ".dcard1"}, dc1, dcm[0]);
        check_val({tag, ".dcard2"}, dc2, dcm[1]);
        check_val({tag, ".dcard3"}, dc3, dcm[2]);
        check_val({tag, ".pscore"}, ps, (val(pcm[0]) + val(pcm[1]) + val(pcm[2])) % 10);
        check_val({tag, ".dscore"}, ds, (val(dcm[0]) + val(dcm[1]) + val(dcm[2])) % 10);
        check_val({tag, ".player_wins"}, pw, sat(cnt_p, 8));
        check_val({tag, ".dealer_wins"}, dw, sat(cnt_d, 8));
        check_val({tag, ".ties"}, tw, sat(cnt_t, 8));
        check_val({tag, ".rounds"}, rw, sat(cnt_r, 8));
        check_val({tag, ".w2_player_wins"}, pw_b, sat(cnt_p, 2));
        check_val({tag, ".w2_dealer_wins"}, dw_b, sat(cnt_d, 2));
        check_val({tag, ".w2_ties"}, tw_b, sat(cnt_t, 2));
        check_val({tag, ".w2_rounds"}, rw_b, sat(cnt_r, 2));
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input string tag, input int card, input logic [5:0] ld,
                         input bit p, input bit d);
        @(negedge slow_clock);
        new_card = 4'(card); loads = ld; pl = p; dl = d;
        @(posedge slow_clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge slow_clock);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge slow_clock);
        reset = 1'b0; loads = 6'd0; pl = 1'b0; dl = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // first two player cards
        cycle("p1_7", 7, 6'b000001, 0, 0);
        cycle("p2_Q", 12, 6'b000010, 0, 0);
        check_val("tp1.pscore", ps, 7);
        check_val("tp1.pcard2", pc2, 12);

        // full hand: 9,8,5 vs K,10,J
        cycle("h_p1", 9, 6'b000001, 0, 0);
        cycle("h_p2", 8, 6'b000010, 0, 0);
        cycle("h_p3", 5, 6'b000100, 0, 0);
        cycle("h_d1", 13, 6'b001000, 0, 0);
        cycle("h_d2", 10, 6'b010000, 0, 0);
        cycle("h_d3", 11, 6'b100000, 0, 0);
        check_val("tp2.pscore", ps, 2);
        check_val("tp2.dscore", ds, 0);
        check_val("tp2.pcard3", pc3b, 5);

        // new round clears the rest
        cycle("newround", 3, 6'b000001, 0, 0);
        check_val("tp3.pcard1", pc1, 3);
        check_val("tp3.dcard1", dc1, 0);
        check_val("tp3.pscore", ps, 3);

        // invalid cards load as 0
        cycle("inv0", 0, 6'b000010, 0, 0);
        cycle("inv15", 15, 6'b000100, 0, 0);
        check_val("tp4.pcard3", pc3, 0);
        check_val("tp4.pscore", ps, 3);

        // same card into several registers at once
        cycle("multi", 4, 6'b110110, 0, 0);

        // light patterns with low gaps
        for (int i = 0; i < 3; i++) cycle("pwin", 0, 6'b0, 1, 0);
        cycle("gap1", 0, 6'b0, 0, 0);
        check_val("tp5.player_wins", pw, 1);
        check_val("tp5.rounds", rw, 1);
        cycle("tie", 0, 6'b0, 1, 1);
        cycle("gap2", 0, 6'b0, 0, 0);
        check_val("tp5.ties", tw, 1);
        cycle("dwin", 0, 6'b0, 0, 1);
        cycle("gap3", 0, 6'b0, 0, 0);
        check_val("tp5.dealer_wins", dw, 1);
        check_val("tp5.rounds3", rw, 3);

        // saturation on the 2-bit copy
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle("sat_hi", 0, 6'b0, 1, 0);
            cycle("sat_lo", 0, 6'b0, 0, 0);
        end
        check_val("tp6.w2_player_wins", pw_b, 3);
        check_val("tp6.w2_rounds", rw_b, 3);
        check_val("tp6.w8_player_wins", pw, 5);

        // asynchronous reset mid-load, loads ignored while reset is high
        cycle("pre_rst_p1", 8, 6'b000001, 0, 0);
        @(negedge slow_clock);
        new_card = 4'd9; loads = 6'b111111; pl = 1'b1; dl = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge slow_clock);
        #1;
        check_all("rst_hold");
        @(negedge slow_clock);
        reset = 1'b0; loads = 6'd0; pl = 1'b0;

        // random stimulus
        for (int n = 0; n < 400; n++) begin
            logic [5:0] ld;
            bit p, d;
            for (int b = 0; b < 6; b++) ld[b] = ($urandom_range(0, 3) == 0);
            if (n % 3 == 0) begin
                p = $urandom_range(0, 1);
                d = $urandom_range(0, 1);
            end else begin
                p = pl;
                d = dl;
            end
            cycle("rand", $urandom_range(0, 15), ld, p, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/baccarat_datapath.md
# baccarat_datapath

Card-holding and scoring datapath for the baccarat round controller. It loads dealt cards into six card registers under the controller's `load_*` strobes. It computes the player and dealer scores and returns them to the controller, along with the player's third card. It also keeps running win/loss/tie tallies across rounds from the controller's win lights.

## Interface
Parameters:
- TALLY_W, 8, width of each round tally counter (saturating).

Ports:
- slow_clock  in  1  single clock; all registers update on the rising edge (controller changes state on the falling edge).
- reset  in  1  asynchronous, active-high; clears every register.
- new_card  in  4  card offered by the dealer source: 1=A, 2..10, 11=J, 12=Q, 13=K; 0, 14 and 15 are invalid.
- load_pcard1, load_pcard2, load_pcard3  in  1 each  load strobes for the player card registers.
- load_dcard1, load_dcard2, load_dcard3  in  1 each  load strobes for the dealer card registers.
- player_win_light, dealer_win_light  in  1 each  controller result lights (both high = tie).
- pcard1_out, pcard2_out, pcard3_out  out  4 each  stored player cards (0 = empty).
- dcard1_out, dcard2_out, dcard3_out  out  4 each  stored dealer cards (0 = empty).
- pcard3  out  4  same value as pcard3_out; feeds the controller's third-card rule.
- pscore, dscore  out  4 each  hand scores, 0..9.
- player_wins, dealer_wins, ties  out  TALLY_W each  round tallies.
- rounds  out  TALLY_W  count of completed rounds.

## Operation
- Card load
  - On a rising edge with load_X high, card register X takes new_card.
  - If new_card is 0, 14 or 15, the register takes 0 instead.
  - Several strobes high on the same edge: every strobed register loads the same value. This is legal and defined.
- New-round clear
  - On an edge where load_pcard1 is high, pcard2, pcard3, dcard1, dcard2 and dcard3 clear to 0, unless their own strobe is high on the same edge, in which case they load.
  - pcard1 loads normally on that edge.
- Card value
  - Stored 1..9 maps to value 1..9.
  - Stored 0 and 10..13 map to value 0.
- Score
  - pscore = (value(pcard1) + value(pcard2) + value(pcard3)) mod 10. The raw sum is at most 27 and is computed 5 bits wide.
  - dscore is computed the same way over the dealer cards.
  - Both scores are combinational from the card registers. No extra register stage.
- Round tally
  - A 1-bit register `result_seen` holds (player_win_light | dealer_win_light) from the previous edge.
  - On an edge where either light is high and result_seen is 0, exactly one tally increments:
    - ties if both lights are high;
    - otherwise player_wins if only player_win_light is high;
    - otherwise dealer_wins.
  - rounds increments on the same edge.
  - Lights held high for several cycles count once. A drop to 0 re-arms counting.
  - Every tally saturates at 2^TALLY_W − 1. A saturated tally holds, while non-saturated tallies keep counting.

## Timing
- Reset values: all card outputs 0, pcard3 0, pscore 0, dscore 0, all tallies 0, result_seen 0.
- Reset asserted mid-round clears everything immediately, without waiting for an edge. Loads are ignored while reset is high.
- Load latency: the card output updates on the rising edge that samples the strobe. pscore, dscore and pcard3 are valid within the same cycle, before the controller's next falling edge.
- Tally latency: the counter updates on the first rising edge that sees a light high.
- No handshake. new_card must be stable around every rising edge on which any load strobe is high.

## Test plan
- Reset, then load_pcard1 with new_card=7, then load_pcard2 with new_card=12 → pcard1_out=7, pcard2_out=12, pscore=7, dscore=0.
- Player cards 9, 8, 5 → pscore=2 (22 mod 10). Dealer cards 13, 10, 11 → dscore=0. pcard3=5.
- After a full round, load_pcard1 with new_card=3 → pcard1_out=3; pcard2, pcard3 and all dealer cards read 0; pscore=3, dscore=0.
- Load invalid values new_card=0, then 15 → the target register reads 0 and the score is unchanged.
- Light patterns, each followed by a low gap:
  - player_win_light high for 3 cycles → player_wins=1, rounds=1;
  - both lights high for 1 cycle → ties=1, rounds=2;
  - dealer_win_light high → dealer_wins=1, rounds=3.
- TALLY_W=2, player_win_light pulsed 5 times → player_wins=3 (saturated), rounds=3 (saturated). Then assert reset mid-load → all outputs 0 asynchronously.
